// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 sink that oversamples driver signals, assembles each latched line and streams it as WIDTH pixel beats.
// Optional on-time counter enabled by defining HUB75_RX_OE_COUNT_EN (oe_cycles tied to 0 otherwise).
module hub75_rx #(
  parameter int WIDTH       = 32,
  parameter int ROW_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mat_r0,
  input  logic                       mat_g0,
  input  logic                       mat_b0,
  input  logic                       mat_r1,
  input  logic                       mat_g1,
  input  logic                       mat_b1,
  input  logic [ROW_BITS-1:0]        mat_row,
  input  logic                       mat_clk,
  input  logic                       mat_lat,
  input  logic                       mat_oe,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [$clog2(WIDTH)-1:0]   pix_x,
  output logic [ROW_BITS-1:0]        pix_row,
  output logic [2:0]                 pix_rgb0,
  output logic [2:0]                 pix_rgb1,
  output logic [$clog2(WIDTH):0]     line_len,
  output logic                       line_done,
  output logic                       line_long,
  output logic                       line_drop,
  output logic [15:0]                oe_cycles
);
  localparam int XW = $clog2(WIDTH);
  localparam int IW = ROW_BITS + 8;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] sync_q [SYNC_STAGES];
  logic [IW-1:0] s;
  logic [5:0] s_data;
  logic [ROW_BITS-1:0] s_row;
  logic s_clk, s_lat, clk_prev, lat_prev, clk_rise, lat_rise;
  logic [5:0] cap_buf [WIDTH];
  logic [5:0] out_buf [WIDTH];
  logic [WIDTH-1:0] mask, mask_nxt;
  logic [XW:0] col, col_nxt;
  logic long_q, long_nxt, cap_wr, cap_ovf, commit, drop, last_beat;
  // data, row, shift clock and latch share one synchronizer so they stay aligned
  assign s        = sync_q[SYNC_STAGES-1];
  assign s_data   = s[5:0];
  assign s_row    = s[6 +: ROW_BITS];
  assign s_clk    = s[ROW_BITS+6];
  assign s_lat    = s[ROW_BITS+7];
  assign clk_rise = s_clk & ~clk_prev;
  assign lat_rise = s_lat & ~lat_prev;
  // synchronizer chain plus one flop for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      clk_prev <= 1'b0;
      lat_prev <= 1'b0;
    end else begin
      sync_q[0] <= {mat_lat, mat_clk, mat_row, mat_r0, mat_g0, mat_b0, mat_r1, mat_g1, mat_b1};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_prev <= s_clk;
      lat_prev <= s_lat;
    end
  end
  // capture bookkeeping including any shift edge that coincides with a latch
  always_comb begin
    cap_wr    = clk_rise && (col < (XW+1)'(WIDTH));
    cap_ovf   = clk_rise && (col == (XW+1)'(WIDTH));
    col_nxt   = col + (XW+1)'(cap_wr);
    long_nxt  = long_q | cap_ovf;
    mask_nxt  = mask | (WIDTH'(cap_wr) << col);
    commit    = lat_rise && (state_q == IDLE);
    drop      = lat_rise && (state_q == STREAM);
    last_beat = pix_ready && (pix_x == XW'(WIDTH-1));
  end
  // column capture; a latch clears the working line whether committed or dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) cap_buf[i] <= '0;
      col    <= '0;
      mask   <= '0;
      long_q <= 1'b0;
    end else begin
      if (cap_wr) cap_buf[col[XW-1:0]] <= s_data;
      col    <= lat_rise ? '0 : col_nxt;
      mask   <= lat_rise ? '0 : mask_nxt;
      long_q <= lat_rise ? 1'b0 : long_nxt;
    end
  end
  // commit copies the line into the stream buffer; unfilled columns read as zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIDTH; i++) out_buf[i] <= '0;
      pix_row   <= '0;
      line_len  <= '0;
      line_long <= 1'b0;
      line_done <= 1'b0;
      line_drop <= 1'b0;
    end else begin
      line_done <= commit;
      line_drop <= drop;
      if (commit) begin
        for (int i = 0; i < WIDTH; i++)
          out_buf[i] <= !mask_nxt[i] ? 6'd0 : (cap_wr && col == (XW+1)'(i)) ? s_data : cap_buf[i];
        pix_row   <= s_row;
        line_len  <= col_nxt;
        line_long <= long_nxt;
      end
    end
  end
  // beat index advances on each accepted beat and wraps after the last column
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pix_x <= '0;
    else if (state_q == STREAM && pix_ready) pix_x <= last_beat ? '0 : pix_x + XW'(1);
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FSM next state: a latch starts a burst, the last accepted beat ends it
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && lat_rise) state_d = STREAM;
    if (state_q == STREAM && last_beat) state_d = IDLE;
  end
  // FSM outputs: pixel data only presented while streaming
  always_comb begin
    pix_valid = state_q == STREAM;
    pix_rgb0  = pix_valid ? out_buf[pix_x][5:3] : 3'd0;
    pix_rgb1  = pix_valid ? out_buf[pix_x][2:0] : 3'd0;
  end
`ifdef HUB75_RX_OE_COUNT_EN
  logic [SYNC_STAGES-1:0] oe_sync;
  logic [15:0] oe_cnt;
  // counts displayed cycles since the previous latch, reported on commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_sync   <= '0;
      oe_cnt    <= '0;
      oe_cycles <= '0;
    end else begin
      oe_sync <= {oe_sync[SYNC_STAGES-2:0], mat_oe};
      if (lat_rise) oe_cnt <= '0;
      else if (!oe_sync[SYNC_STAGES-1] && oe_cnt != 16'hFFFF) oe_cnt <= oe_cnt + 16'd1;
      if (commit) oe_cycles <= oe_cnt;
    end
  end
`else
  logic unused_oe;
  assign unused_oe = mat_oe;
  assign oe_cycles = '0;
`endif
endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: scoreboard bench for hub75_rx driving HUB75 line transfers and checking pixel bursts.
module tb_hub75_rx;
  localparam int W = 32;
  typedef struct packed {
    logic [4:0] x;
    logic [3:0] row;
    logic [2:0] rgb0;
    logic [2:0] rgb1;
  } beat_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mat_r0 = 0, mat_g0 = 0, mat_b0 = 0, mat_r1 = 0, mat_g1 = 0, mat_b1 = 0;
  logic [3:0] mat_row = '0;
  logic mat_clk = 0, mat_lat = 0, mat_oe = 1;
  logic pix_valid, pix_ready = 1'b1;
  logic [4:0] pix_x;
  logic [3:0] pix_row;
  logic [2:0] pix_rgb0, pix_rgb1;
  logic [5:0] line_len;
  logic line_done, line_long, line_drop;
  logic [15:0] oe_cycles;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  beat_t q[$];
  beat_t e;
  logic [5:0] dat [64];

  hub75_rx #(.WIDTH(W), .ROW_BITS(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .mat_r0(mat_r0), .mat_g0(mat_g0), .mat_b0(mat_b0),
    .mat_r1(mat_r1), .mat_g1(mat_g1), .mat_b1(mat_b1),
    .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_row(pix_row),
    .pix_rgb0(pix_rgb0), .pix_rgb1(pix_rgb1), .line_len(line_len),
    .line_done(line_done), .line_long(line_long), .line_drop(line_drop),
    .oe_cycles(oe_cycles)
  );

  always #5 clk = ~clk;

  // scoreboard: every accepted beat must match the oldest expected beat
  always @(negedge clk) begin
    if (rst) begin
      if (line_done) done_cnt++;
      if (line_drop) drop_cnt++;
      if (pix_valid && pix_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got x=%0d rgb0=%0d rgb1=%0d want no beat", pix_x, pix_rgb0, pix_rgb1);
        end else begin
          e = q.pop_front();
          if ({pix_x, pix_row, pix_rgb0, pix_rgb1} !== e) begin
            failures++;
            $display("FAIL beat got x=%0d row=%0d rgb0=%0d rgb1=%0d want x=%0d row=%0d rgb0=%0d rgb1=%0d",
                     pix_x, pix_row, pix_rgb0, pix_rgb1, e.x, e.row, e.rgb0, e.rgb1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edge6(input logic [5:0] d, input logic with_lat);
    {mat_r0, mat_g0, mat_b0, mat_r1, mat_g1, mat_b1} = d;
    tick(2);
    mat_clk = 1'b1;
    mat_lat = with_lat;
    tick(3);
    mat_clk = 1'b0;
    mat_lat = 1'b0;
    tick(2);
  endtask

  task automatic send_edges(input int n);
    for (int i = 0; i < n; i++) edge6(dat[i], 1'b0);
  endtask

  task automatic push_line(input int n, input logic [3:0] row);
    logic [5:0] d;
    for (int x = 0; x < W; x++) begin
      d = (x < n) ? dat[x] : 6'd0;
      q.push_back('{5'(x), row, d[5:3], d[2:0]});
    end
  endtask

  task automatic wait_done(input int d0, input int exp_len, input logic exp_long, input string name);
    for (int i = 0; i < 50 && done_cnt == d0; i++) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL %s_done got %0d pulses want 1", name, done_cnt - d0);
    end
    checks++;
    if (line_len !== 6'(exp_len)) begin
      failures++;
      $display("FAIL %s_len got %0d want %0d", name, line_len, exp_len);
    end
    checks++;
    if (line_long !== exp_long) begin
      failures++;
      $display("FAIL %s_long got %0b want %0b", name, line_long, exp_long);
    end
  endtask

  task automatic latch(input int exp_len, input logic exp_long, input string name);
    int d0;
    d0 = done_cnt;
    mat_lat = 1'b1;
    tick(3);
    mat_lat = 1'b0;
    wait_done(d0, exp_len, exp_long, name);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d beats missing want 0", name, q.size());
    end
    tick(40);
    checks++;
    if (pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle got valid=%0b want 0", name, pix_valid);
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({pix_valid, pix_x, pix_row, pix_rgb0, pix_rgb1, line_len, line_done, line_long, line_drop, oe_cycles} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b x=%0d len=%0d done=%0b want all 0", pix_valid, pix_x, line_len, line_done);
    end
    rst = 1'b1;
    tick(5);
    checks++;
    if ({pix_valid, line_len, line_done, line_drop} !== '0) begin
      failures++;
      $display("FAIL reset_release got valid=%0b len=%0d want 0", pix_valid, line_len);
    end
  endtask

  task automatic test_full;
    logic [2:0] t;
    for (int i = 0; i < W; i++) begin
      t = 3'(i);
      dat[i] = {t, ~t};
    end
    mat_row = 4'd5;
    pix_ready = 1'b1;
    push_line(W, 4'd5);
    send_edges(W);
    latch(W, 1'b0, "full");
    drain("full");
  endtask

  task automatic test_short;
    for (int i = 0; i < 64; i++) dat[i] = 6'($urandom_range(1, 63));
    mat_row = 4'd12;
    push_line(10, 4'd12);
    send_edges(10);
    latch(10, 1'b0, "short");
    drain("short");
  endtask

  task automatic test_long;
    for (int i = 0; i < 64; i++) dat[i] = 6'($urandom_range(1, 63));
    mat_row = 4'd7;
    push_line(W, 4'd7);
    send_edges(35);
    latch(W, 1'b1, "long");
    drain("long");
  endtask

  task automatic test_drop;
    int dc, dd;
    logic [5:0] d0;
    for (int i = 0; i < 64; i++) dat[i] = 6'((i * 5 + 3) & 63);
    d0 = dat[0];
    mat_row = 4'd9;
    pix_ready = 1'b0;
    push_line(W, 4'd9);
    send_edges(W);
    latch(W, 1'b0, "drop_first");
    tick(5);
    checks++;
    if (pix_valid !== 1'b1 || pix_x !== 5'd0 || pix_rgb0 !== d0[5:3] || pix_rgb1 !== d0[2:0]) begin
      failures++;
      $display("FAIL drop_hold got valid=%0b x=%0d rgb0=%0d rgb1=%0d want 1 0 %0d %0d",
               pix_valid, pix_x, pix_rgb0, pix_rgb1, d0[5:3], d0[2:0]);
    end
    dc = done_cnt;
    dd = drop_cnt;
    mat_row = 4'd2;
    for (int i = 0; i < 4; i++) edge6(6'h3F, 1'b0);
    mat_lat = 1'b1;
    tick(3);
    mat_lat = 1'b0;
    tick(6);
    checks++;
    if (drop_cnt != dd + 1 || done_cnt != dc) begin
      failures++;
      $display("FAIL drop_pulse got drops=%0d dones=%0d want drops=1 dones=0", drop_cnt - dd, done_cnt - dc);
    end
    checks++;
    if (line_len !== 6'd32 || pix_row !== 4'd9) begin
      failures++;
      $display("FAIL drop_keep got len=%0d row=%0d want len=32 row=9", line_len, pix_row);
    end
    pix_ready = 1'b1;
    drain("drop");
  endtask

  task automatic test_same_cycle;
    int d0;
    for (int i = 0; i < 64; i++) dat[i] = 6'($urandom_range(1, 63));
    mat_row = 4'd1;
    push_line(8, 4'd1);
    send_edges(7);
    d0 = done_cnt;
    edge6(dat[7], 1'b1);
    wait_done(d0, 8, 1'b0, "same_cycle");
    drain("same_cycle");
  endtask

  task automatic test_oe;
    mat_oe = 1'b0;
    tick(100);
    mat_oe = 1'b1;
    tick(5);
    mat_row = 4'd0;
    push_line(0, 4'd0);
    latch(0, 1'b0, "oe");
    checks++;
`ifdef HUB75_RX_OE_COUNT_EN
    if (oe_cycles !== 16'd100) begin
      failures++;
      $display("FAIL oe_cycles got %0d want 100", oe_cycles);
    end
`else
    if (oe_cycles !== 16'd0) begin
      failures++;
      $display("FAIL oe_cycles got %0d want 0", oe_cycles);
    end
`endif
    drain("oe");
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 64; i++) dat[i] = 6'($urandom_range(1, 63));
    mat_row = 4'd4;
    pix_ready = 1'b0;
    push_line(4, 4'd4);
    send_edges(4);
    latch(4, 1'b0, "rst_mid");
    tick(3);
    checks++;
    if (pix_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_stream got valid=%0b want 1", pix_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({pix_valid, pix_x, pix_row, pix_rgb0, pix_rgb1, line_len, line_done, line_long, line_drop, oe_cycles} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got valid=%0b row=%0d len=%0d rgb0=%0d want all 0", pix_valid, pix_row, line_len, pix_rgb0);
    end
    q.delete();
    tick(3);
    rst = 1'b1;
    pix_ready = 1'b1;
    tick(3);
    for (int i = 0; i < W; i++) dat[i] = 6'(i + 17);
    mat_row = 4'd3;
    push_line(W, 4'd3);
    send_edges(W);
    latch(W, 1'b0, "after_rst");
    drain("after_rst");
  endtask

  initial begin
    test_reset;
    test_full;
    test_short;
    test_long;
    test_drop;
    test_same_cycle;
    test_oe;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Sink-side model of the HUB75 dot-matrix interface; captures the signals a matrix driver emits (dual-half RGB data, mat_clk, mat_lat, mat_oe, row address), as a physical panel would.
- Oversamples all inputs on the system clock, assembles one shifted line per latch, and streams it out as a valid/ready pixel stream.
- Used as an in-fabric loopback checker for the matrix driver and as a bench monitor.

Parameters:
- WIDTH, 32, columns per shifted line; pixels per output burst.
- ROW_BITS, 4, width of the row address bus.
- SYNC_STAGES, 2, synchronizer depth on all mat_* inputs (minimum 2).

Ports:
- clk  in  1  system clock; all logic in this domain.
- rst  in  1  asynchronous, active-low reset.
- mat_r0, mat_g0, mat_b0  in  1 each  upper-half pixel data.
- mat_r1, mat_g1, mat_b1  in  1 each  lower-half pixel data.
- mat_row  in  ROW_BITS  row address; bit 0 is mat_row0.
- mat_clk  in  1  shift clock; data captured on its rising edge.
- mat_lat  in  1  latch; line committed on its rising edge.
- mat_oe  in  1  output enable, active-low.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream ready.
- pix_x  out  clog2(WIDTH)  column index of the current beat.
- pix_row  out  ROW_BITS  row address sampled at latch.
- pix_rgb0  out  3  {r,g,b} upper half.
- pix_rgb1  out  3  {r,g,b} lower half.
- line_len  out  clog2(WIDTH)+1  mat_clk edges counted in the last committed line.
- line_done  out  1  one-cycle pulse at each latch commit.
- line_long  out  1  with line_done: more than WIDTH edges arrived (extras discarded).
- line_drop  out  1  one-cycle pulse: latch arrived while streaming; that line is discarded.
- oe_cycles  out  16  see Optional Feature.

Behaviour:
- Input synchronization
  - All mat_* inputs pass through SYNC_STAGES flops.
  - Data and row use the same depth as mat_clk and mat_lat, so they stay aligned.
  - Edges are detected one flop past the synchronizer.
  - Each mat_clk and mat_lat high or low phase must last at least 2 clk cycles; shorter phases are unspecified.
- Capture
  - Column counter col (0..WIDTH) resets to 0.
  - On a mat_clk rising edge with col < WIDTH: write 6-bit data to cap_buf[col], set mask[col], increment col.
  - On a mat_clk rising edge with col == WIDTH: set the long flag; data is discarded; col saturates at WIDTH.
  - First edge after a latch is x=0.
- Commit, on a mat_lat rising edge
  - If a mat_clk edge falls in the same cycle, it is processed first.
  - If the FSM is IDLE:
    - Copy cap_buf into out_buf; columns with mask=0 become 0.
    - Capture mat_row into pix_row; set line_len=col and line_long=long.
    - Pulse line_done; enter STREAM with pix_x=0.
  - If the FSM is in STREAM: pulse line_drop, discard the line, leave line_len and line_long unchanged.
  - In both cases: clear col, mask and long.
- FSM
  - IDLE: pix_valid=0.
  - STREAM: pix_valid=1; pix_rgb0, pix_rgb1 = out_buf[pix_x].
  - On pix_valid & pix_ready: pix_x increments.
  - At pix_x == WIDTH-1 with handshake: go to IDLE, pix_x=0.
  - Outputs are held stable while valid and not ready.
  - Exactly WIDTH beats per committed line, even for short lines.
  - Capture continues during STREAM; only a commit is blocked.
- Latency: first pix_valid occurs SYNC_STAGES+1 clk cycles after the mat_lat rising edge.
- Reset (rst low, asynchronous)
  - All outputs, counters, buffers, synchronizers and flags go to 0; FSM goes to IDLE.
  - A reset mid-stream or mid-capture abandons that line with no pulses.
  - After release, the first line begins at the next mat_clk edge.

Optional Feature:
- Macro: HUB75_RX_OE_COUNT_EN.
- Defined:
  - A 16-bit counter increments each clk cycle the synchronized mat_oe is 0, saturating at 16'hFFFF.
  - At commit (IDLE path only) its value is copied to oe_cycles and the counter clears; on the drop path the counter also clears.
  - This measures display (brightness) time of the previous line.
- Not defined: oe_cycles is tied to 0 and no counter logic exists.

Test Plan:
- 32 mat_clk edges with column i carrying upper {r,g,b}=i[2:0], lower=~i[2:0], mat_row=5, then latch, pix_ready=1 -> line_done, line_len=32, line_long=0; 32 beats x=0..31, pix_row=5, rgb match.
- 10 edges then latch -> line_len=10; beats x=10..31 carry rgb 0; still 32 beats.
- 35 edges then latch -> line_long=1, line_len=32; columns 32..34 absent.
- Second latch while pix_ready=0 mid-stream -> line_drop pulse; first stream resumes unchanged when ready returns; no second burst.
- mat_clk and mat_lat rising in the same cycle as the 8th edge -> line_len=8; column 7 present.
- With HUB75_RX_OE_COUNT_EN: mat_oe low for 100 clk cycles, then latch -> oe_cycles=100. rst low mid-stream -> pix_valid=0 immediately, all outputs 0.
